cobs_uart_tx: RTL and testbench

COBS-encoding UART transmitter: the outbound counterpart of the host-side UART/COBS command receiver used for VRAM writes. Accepts a packet as a byte stream (valid/ready/last), COBS-encodes it and serialises it on txd as 8N1 frames terminated by a 0x00 delimiter. Used to return VRAM readback and status packets to the host over the same serial link.

---
 rtl/cobs_uart_tx_if.sv | 15 +
 rtl/cobs_uart_tx.sv | 191 +++++++++++++++++++
 tb/tb_cobs_uart_tx.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cobs_uart_tx_if.sv
// cobs_uart_tx_if: packet byte-stream handshake into the COBS UART transmitter.
//   in_data  : packet byte
//   in_valid : in_data valid
//   in_last  : in_data is the final byte of the packet
//   in_ready : transmitter accepts a byte this cycle
// master = byte source, slave = cobs_uart_tx.
interface cobs_uart_tx_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;

    modport master (output in_data, output in_valid, output in_last, input in_ready);
    modport slave  (input in_data, input in_valid, input in_last, output in_ready);
endinterface

// File: rtl/cobs_uart_tx.sv
// cobs_uart_tx: COBS-encodes an inbound packet byte stream and serialises it
// on txd as UART frames, terminating each packet with a 0x00 delimiter.
// Ports:
//   clk    : system clock
//   rst    : asynchronous active-high reset
//   in_if  : byte stream (in_data/in_valid/in_last/in_ready), slave side
//   txd    : UART serial output, idle high
//   busy   : packet in progress (first accepted byte until delimiter stop bit ends)
// Optional build macro COBS_TX_PARITY_EN: frames become 8E1 (even parity bit
// between D7 and stop) instead of 8N1.
module cobs_uart_tx #(
    parameter int CLKS_PER_BIT = 644,
    parameter int MAX_BLOCK    = 254
) (
    input  logic          clk,
    input  logic          rst,
    cobs_uart_tx_if.slave in_if,
    output logic          txd,
    output logic          busy
);
`ifdef COBS_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       BIT_LAST = 4'(FRAME_BITS - 1);
    localparam logic [7:0]       MAX_CNT  = 8'(MAX_BLOCK);

    typedef enum logic [2:0] {ST_FILL, ST_CODE, ST_DATA, ST_TAIL, ST_DELIM} state_t;

    state_t     state_q, state_d, post_st;
    logic [7:0] cnt_q, cnt_d, idx_q, idx_d, cnt_inc;
    logic       ended_q, ended_d, zend_q, zend_d, busy_q, busy_d, sent_q, sent_d;

    logic                  tx_act_q;
    logic [CNT_W-1:0]      clk_cnt_q;
    logic [3:0]            bit_q;
    logic [FRAME_BITS-1:0] frame_q, frame_ld;
    logic                  frame_done, ser_rdy, ld;
    logic [7:0]            ld_byte;

    logic [7:0] mem [MAX_BLOCK];
    logic [7:0] rd_q;
    logic       accept, zero_in, wr_en;

    assign in_if.in_ready = (state_q == ST_FILL) && !rst;
    assign accept         = in_if.in_valid && in_if.in_ready;
    assign zero_in        = (in_if.in_data == 8'h00);
    assign wr_en          = accept && !zero_in;
    assign cnt_inc        = cnt_q + 8'd1;

    // The serialiser can take a new byte while idle or in the final cycle of
    // a stop bit, which makes back-to-back frames gapless.
    assign frame_done = tx_act_q && (clk_cnt_q == CNT_LAST) && (bit_q == BIT_LAST);
    assign ser_rdy    = !tx_act_q || frame_done;
    assign txd        = tx_act_q ? frame_q[0] : 1'b1;
    assign busy       = busy_q;

`ifdef COBS_TX_PARITY_EN
    assign frame_ld = {1'b1, ^ld_byte, ld_byte, 1'b0};
`else
    assign frame_ld = {1'b1, ld_byte, 1'b0};
`endif

    // Block buffer. The read is registered every cycle from idx_q; data loads
    // are at least one frame apart so rd_q is always settled when used.
    always_ff @(posedge clk) begin
        if (wr_en) mem[cnt_q] <= in_if.in_data;
        rd_q <= mem[(idx_q < MAX_CNT) ? idx_q : 8'd0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_act_q  <= 1'b0;
            clk_cnt_q <= '0;
            bit_q     <= '0;
            frame_q   <= '1;
        end else if (ld) begin
            tx_act_q  <= 1'b1;
            clk_cnt_q <= '0;
            bit_q     <= '0;
            frame_q   <= frame_ld;
        end else if (tx_act_q) begin
            if (clk_cnt_q == CNT_LAST) begin
                clk_cnt_q <= '0;
                frame_q   <= {1'b1, frame_q[FRAME_BITS-1:1]};
                if (bit_q == BIT_LAST) tx_act_q <= 1'b0;
                else                   bit_q    <= bit_q + 4'd1;
            end else begin
                clk_cnt_q <= clk_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FILL;
            cnt_q   <= '0;
            idx_q   <= '0;
            ended_q <= 1'b0;
            zend_q  <= 1'b0;
            busy_q  <= 1'b0;
            sent_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ended_q <= ended_d;
            zend_q  <= zend_d;
            busy_q  <= busy_d;
            sent_q  <= sent_d;
        end
    end

    // Where to go once a block's bytes are out: a trailing zero needs the
    // empty final block (0x01); a packet ending at a full 0xFF block or on a
    // non-zero byte goes straight to the delimiter.
    assign post_st = ended_q ? (zend_q ? ST_TAIL : ST_DELIM) : ST_FILL;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        ended_d = ended_q;
        zend_d  = zend_q;
        busy_d  = busy_q;
        sent_d  = sent_q;
        ld      = 1'b0;
        ld_byte = 8'h00;
        case (state_q)
            ST_FILL: begin
                if (accept) begin
                    busy_d = 1'b1;
                    if (!zero_in) cnt_d = cnt_inc;
                    if (zero_in || in_if.in_last || cnt_inc == MAX_CNT) begin
                        state_d = ST_CODE;
                        ended_d = in_if.in_last;
                        zend_d  = in_if.in_last && zero_in;
                        idx_d   = 8'd0;
                    end
                end
            end
            ST_CODE: begin
                if (ser_rdy) begin
                    ld      = 1'b1;
                    ld_byte = cnt_q + 8'd1;
                    state_d = (cnt_q == 8'd0) ? post_st : ST_DATA;
                end
            end
            ST_DATA: begin
                if (ser_rdy) begin
                    ld      = 1'b1;
                    ld_byte = rd_q;
                    idx_d   = idx_q + 8'd1;
                    if (idx_q == cnt_q - 8'd1) begin
                        state_d = post_st;
                        cnt_d   = 8'd0;
                    end
                end
            end
            ST_TAIL: begin
                if (ser_rdy) begin
                    ld      = 1'b1;
                    ld_byte = 8'h01;
                    state_d = ST_DELIM;
                end
            end
            ST_DELIM: begin
                // sent_q separates "delimiter not yet loaded" from "waiting for
                // its stop bit", since frame_done may belong to the prior frame.
                if (!sent_q) begin
                    if (ser_rdy) begin
                        ld      = 1'b1;
                        ld_byte = 8'h00;
                        sent_d  = 1'b1;
                    end
                end else if (frame_done) begin
                    sent_d  = 1'b0;
                    busy_d  = 1'b0;
                    cnt_d   = 8'd0;
                    ended_d = 1'b0;
                    zend_d  = 1'b0;
                    state_d = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end
endmodule

// File: tb/tb_cobs_uart_tx.sv
module tb_cobs_uart_tx;
    localparam int CLKS = 4;
    localparam int MAXB = 254;
`ifdef COBS_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FCYC  = NB * CLKS;
    localparam int LIMIT = 300 * FCYC;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        int          n;
        logic [63:0] d;
        int          en;
        logic [95:0] e;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic txd, busy;
    cobs_uart_tx_if bus();

    cobs_uart_tx #(.CLKS_PER_BIT(CLKS), .MAX_BLOCK(MAXB)) dut (
        .clk(clk), .rst(rst), .in_if(bus), .txd(txd), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int starts = 0;
    int acc_cnt = 0;
    bq_t rx_q;
    int  rx_t[$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (!rst && bus.in_valid && bus.in_ready) acc_cnt++;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // UART receiver: samples mid-bit, checks framing, records byte + start cycle.
    int              m_t0, m_w;
    logic            m_abort;
    logic [NB-1:0]   m_bits;
    always begin
        @(negedge clk);
        if (!rst && txd === 1'b0) begin
            m_t0 = cyc;
            starts++;
            m_abort = 1'b0;
            for (int k = 0; k < NB; k++) begin
                m_w = (k == 0) ? CLKS / 2 : CLKS;
                for (int j = 0; j < m_w; j++) begin
                    @(negedge clk);
                    if (rst) m_abort = 1'b1;
                end
                if (m_abort) break;
                m_bits[k] = txd;
            end
            if (!m_abort)
                for (int j = 0; j < CLKS - CLKS / 2 - 1; j++) begin
                    @(negedge clk);
                    if (rst) m_abort = 1'b1;
                end
            if (!m_abort) begin
                check("frame_start", int'(m_bits[0]), 0);
                check("frame_stop", int'(m_bits[NB-1]), 1);
`ifdef COBS_TX_PARITY_EN
                check("frame_parity", int'(m_bits[9]), int'(^m_bits[8:1]));
`endif
                rx_q.push_back(m_bits[8:1]);
                rx_t.push_back(m_t0);
            end
        end
    end

    // Reference COBS encoder (0xFF blocks carry no implied zero).
    task automatic cobs_ref(input bq_t pkt, output bq_t enc);
        bq_t blk;
        enc = {};
        blk = {};
        foreach (pkt[i]) begin
            if (pkt[i] == 8'h00) begin
                enc.push_back(8'(blk.size() + 1));
                foreach (blk[j]) enc.push_back(blk[j]);
                blk = {};
            end else begin
                blk.push_back(pkt[i]);
                if (blk.size() == MAXB) begin
                    enc.push_back(8'hFF);
                    foreach (blk[j]) enc.push_back(blk[j]);
                    blk = {};
                end
            end
        end
        if (pkt[pkt.size()-1] == 8'h00) enc.push_back(8'h01);
        else if (blk.size() > 0) begin
            enc.push_back(8'(blk.size() + 1));
            foreach (blk[j]) enc.push_back(blk[j]);
        end
        enc.push_back(8'h00);
    endtask

    // Called #1 after a posedge; returns #1 after the posedge of the last accept.
    task automatic send_pkt(input bq_t pkt, input int stall_pct);
        logic rdy;
        for (int i = 0; i < pkt.size(); i++) begin
            int  waited;
            logic done;
            waited = 0;
            done   = 1'b0;
            while (!done) begin
                bus.in_valid = ($urandom_range(99) >= stall_pct);
                bus.in_data  = bus.in_valid ? pkt[i] : 8'($urandom);
                bus.in_last  = bus.in_valid ? (i == pkt.size() - 1) : 1'($urandom);
                @(negedge clk);
                rdy = bus.in_ready;
                @(posedge clk);
                #1;
                if (rdy && bus.in_valid) done = 1'b1;
                else if (++waited > 20000) begin
                    check("accept_timeout", 0, 1);
                    bus.in_valid = 1'b0;
                    return;
                end
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic run(input string name, input bq_t pkt, input bq_t exp,
                       input int stall, input logic gapchk);
        int bad, n, m;
        rx_q = {};
        rx_t = {};
        acc_cnt = 0;
        send_pkt(pkt, stall);
        bad = 0;
        n = 0;
        do begin
            @(negedge clk);
            if (busy && bus.in_ready) bad++;
            n++;
        end while (busy !== 1'b0 && n < LIMIT);
        check({name, "_done"}, int'(n < LIMIT), 1);
        check({name, "_ready_low"}, bad, 0);
        check({name, "_ready_after"}, int'(bus.in_ready), 1);
        repeat (2) @(negedge clk);
        check({name, "_len"}, rx_q.size(), exp.size());
        m = (rx_q.size() < exp.size()) ? rx_q.size() : exp.size();
        for (int i = 0; i < m; i++)
            check($sformatf("%s_byte%0d", name, i), int'(rx_q[i]), int'(exp[i]));
        check({name, "_accepted"}, acc_cnt, pkt.size());
        if (gapchk) begin
            bad = 0;
            for (int i = 1; i < rx_t.size(); i++)
                if (rx_t[i] - rx_t[i-1] != FCYC) bad++;
            check({name, "_frame_spacing"}, bad, 0);
        end
        @(posedge clk);
        #1;
    endtask

    vec_t vt[8];
    bq_t  p, e;
    int   s0, n;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{4, 64'h11220033, 6, 96'h031122023300};
        vt[1] = '{1, 64'h00,       3, 96'h010100};
        vt[2] = '{1, 64'h42,       3, 96'h024200};
        vt[3] = '{1, 64'h03,       3, 96'h020300};
        vt[4] = '{1, 64'h01,       3, 96'h020100};
        vt[5] = '{2, 64'h0000,     4, 96'h01010100};
        vt[6] = '{3, 64'h110022,   5, 96'h0211022200};
        vt[7] = '{2, 64'h1100,     4, 96'h02110100};

        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_txd", int'(txd), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_ready", int'(bus.in_ready), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table vectors, no stalls: exact bytes and gapless frames.
        foreach (vt[v]) begin
            p = {};
            e = {};
            for (int i = 0; i < vt[v].n; i++) p.push_back(vt[v].d[8*(vt[v].n-1-i) +: 8]);
            for (int i = 0; i < vt[v].en; i++) e.push_back(vt[v].e[8*(vt[v].en-1-i) +: 8]);
            run($sformatf("vec%0d", v), p, e, 0, 1'b1);
        end

        // Full-block boundaries.
        p = {};
        for (int i = 1; i <= 254; i++) p.push_back(8'(i));
        cobs_ref(p, e);
        run("blk254", p, e, 0, 1'b1);
        check("blk254_size", rx_q.size(), 256);
        p.push_back(8'hFF);
        cobs_ref(p, e);
        run("blk255", p, e, 0, 1'b1);
        check("blk255_size", rx_q.size(), 258);
        if (rx_q.size() == 258) check("blk255_tailcode", int'(rx_q[255]), 8'h02);

        // Randomised packets with stalls.
        for (int r = 0; r < 4; r++) begin
            p = {};
            n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) begin
                int c;
                c = $urandom_range(99);
                p.push_back(c < 40 ? 8'h00 : c < 80 ? 8'h55 : 8'($urandom_range(1, 255)));
            end
            cobs_ref(p, e);
            run($sformatf("rnd%0d", r), p, e, 30, 1'b0);
        end
        p = {};
        for (int i = 0; i < 270; i++)
            p.push_back($urandom_range(99) < 2 ? 8'h00 : 8'($urandom_range(1, 255)));
        cobs_ref(p, e);
        run("rndlong", p, e, 20, 1'b0);

        // Reset during the start bit of the second frame.
        p = {8'h11, 8'h22};
        s0 = starts;
        send_pkt(p, 0);
        n = 0;
        while (starts < s0 + 2 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("rst_second_start_seen", int'(n < LIMIT), 1);
        #2;
        check("rst_pre_txd", int'(txd), 0);
        rst = 1'b1;
        #1;
        check("rst_txd", int'(txd), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(bus.in_ready), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_release_ready", int'(bus.in_ready), 1);
        check("rst_release_txd", int'(txd), 1);
        p = {8'h42};
        e = {8'h02, 8'h42, 8'h00};
        run("after_rst", p, e, 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
